// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Keeps the PC, issues word fetches over a req/ready handshake, absorbs
// decode back-pressure with a one-word hold buffer and handles redirects
// without ever abandoning a request that is already on the bus.
//
// state | meaning
// FETCH | request on the bus at req_addr; responses go to IF/ID (or hold)
// DRAIN | redirect arrived mid-request; wait for the stale response, drop it
// HOLD  | response captured while decode stalled; bus idle until release
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_1000,
  parameter logic [31:0] NOP_INSTR = 32'hFE00_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // PC is stored word-aligned so imem_addr[1:0] is structurally zero.
  localparam logic [31:0] RESET_PC_AL = RESET_PC & 32'hFFFF_FFFC;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] req_addr;
  logic [31:0] req_addr_nxt;
  logic [31:0] hold_instr;
  logic [31:0] hold_nxt;
  logic [31:0] pc_inc;
  logic [31:0] redirect_pc_al;

  // IF/ID update controls: clear inserts a bubble, load writes a real word.
  logic        ifid_clear;
  logic        ifid_load;
  logic [31:0] ifid_instr_in;
  logic [31:0] ifid_pc_in;
  logic [31:0] if_instr_nxt;
  logic [31:0] if_pc_nxt;
  logic        if_valid_nxt;

  assign pc_inc         = pc + 32'd4;
  assign redirect_pc_al = redirect_pc & 32'hFFFF_FFFC;

  // The bus sees nothing while reset is held, even though state is FETCH.
  assign imem_req  = !reset && (state != HOLD);
  assign imem_addr = req_addr;

  // State, PC, request address and hold buffer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_PC_AL;
      req_addr   <= RESET_PC_AL;
      hold_instr <= 32'h0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      req_addr   <= req_addr_nxt;
      hold_instr <= hold_nxt;
    end
  end

  // Next-state logic; redirect outranks stall in every state.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    req_addr_nxt  = req_addr;
    hold_nxt      = hold_instr;
    ifid_clear    = 1'b0;
    ifid_load     = 1'b0;
    ifid_instr_in = imem_rdata;
    ifid_pc_in    = req_addr;

    case (state)
      FETCH: begin
        if (redirect) begin
          ifid_clear = 1'b1;
          pc_nxt     = redirect_pc_al;
          if (imem_ready) begin
            req_addr_nxt = redirect_pc_al;
          end else begin
            // Request stays on the bus at the old address until it completes.
            state_nxt = DRAIN;
          end
        end else if (imem_ready) begin
          pc_nxt = pc_inc;
          if (stall) begin
            hold_nxt  = imem_rdata;
            state_nxt = HOLD;
          end else begin
            ifid_load     = 1'b1;
            ifid_instr_in = imem_rdata;
            ifid_pc_in    = req_addr;
            req_addr_nxt  = pc_inc;
          end
        end else if (!stall) begin
          ifid_clear = 1'b1;
        end
      end

      DRAIN: begin
        if (redirect) begin
          ifid_clear = 1'b1;
          pc_nxt     = redirect_pc_al;
        end else if (!stall) begin
          ifid_clear = 1'b1;
        end
        if (imem_ready) begin
          // Stale word is discarded; the next launch uses the newest target.
          req_addr_nxt = pc_nxt;
          state_nxt    = FETCH;
        end
      end

      HOLD: begin
        if (redirect) begin
          ifid_clear   = 1'b1;
          pc_nxt       = redirect_pc_al;
          req_addr_nxt = redirect_pc_al;
          state_nxt    = FETCH;
        end else if (!stall) begin
          // req_addr still names the held word; pc already points past it.
          ifid_load     = 1'b1;
          ifid_instr_in = hold_instr;
          ifid_pc_in    = req_addr;
          req_addr_nxt  = pc;
          state_nxt     = FETCH;
        end
      end

      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  // IF/ID next value: bubble, new word, or hold current contents.
  always_comb begin
    if_instr_nxt = if_instr;
    if_pc_nxt    = if_pc;
    if_valid_nxt = if_valid;
    if (ifid_clear) begin
      if_instr_nxt = NOP_INSTR;
      if_pc_nxt    = 32'h0;
      if_valid_nxt = 1'b0;
    end else if (ifid_load) begin
      if_instr_nxt = ifid_instr_in;
      if_pc_nxt    = ifid_pc_in;
      if_valid_nxt = 1'b1;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_instr <= NOP_INSTR;
      if_pc    <= 32'h0;
      if_valid <= 1'b0;
    end else begin
      if_instr <= if_instr_nxt;
      if_pc    <= if_pc_nxt;
      if_valid <= if_valid_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run compared against a transaction-level reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hFE00_0000;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_valid   (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference model: where the bus is, whether its reply is wanted, and a
  // parked word waiting for decode; plus the expected IF/ID contents.
  logic [31:0] m_pc, m_addr, m_park;
  logic        m_stale, m_parked;
  logic [31:0] e_i, e_pc;
  logic        e_v;

  task automatic model_reset();
    m_pc = 32'h1000; m_addr = 32'h1000; m_park = 32'h0;
    m_stale = 1'b0; m_parked = 1'b0;
    e_i = NOP; e_pc = 32'h0; e_v = 1'b0;
  endtask

  task automatic model_bubble();
    e_i = NOP; e_pc = 32'h0; e_v = 1'b0;
  endtask

  task automatic model_step(input logic rdy, input logic stl, input logic rd,
                            input logic [31:0] rpc);
    logic [31:0] rp;
    logic [31:0] w;
    rp = rpc & 32'hFFFF_FFFC;
    w  = mem_word(m_addr);
    if (m_parked) begin
      if (rd) begin
        m_parked = 1'b0; m_pc = rp; m_addr = rp; model_bubble();
      end else if (!stl) begin
        e_i = m_park; e_pc = m_addr; e_v = 1'b1;
        m_parked = 1'b0; m_addr = m_pc;
      end
    end else if (m_stale) begin
      if (rd) begin m_pc = rp; model_bubble(); end
      else if (!stl) model_bubble();
      if (rdy) begin m_stale = 1'b0; m_addr = m_pc; end
    end else if (rd) begin
      model_bubble();
      m_pc = rp;
      if (rdy) m_addr = rp; else m_stale = 1'b1;
    end else if (rdy) begin
      if (stl) begin
        m_park = w; m_parked = 1'b1;
      end else begin
        e_i = w; e_pc = m_addr; e_v = 1'b1;
        m_addr = m_addr + 32'd4;
      end
      m_pc = m_pc + 32'd4;
    end else if (!stl) begin
      model_bubble();
    end
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic tick(input logic rdy, input logic stl, input logic rd,
                      input logic [31:0] rpc);
    imem_ready  = rdy;
    stall       = stl;
    redirect    = rd;
    redirect_pc = rpc;
    imem_rdata  = rdy ? mem_word(m_addr) : 32'hDEAD_BEEF;
    model_step(rdy, stl, rd, rpc);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; imem_ready = 1'b0; stall = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; imem_rdata = 32'h0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_ready = 1'b0; stall = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; imem_rdata = 32'h0;
    model_reset();
    @(posedge clk);
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", if_valid); end
    n_checks++; if (if_instr !== NOP) begin n_fail++; $display("FAIL rst_instr got=%h exp=%h", if_instr, NOP); end
    n_checks++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got=%h exp=0", if_pc); end
    n_checks++; if (imem_addr !== 32'h1000) begin n_fail++; $display("FAIL rst_addr got=%h exp=1000", imem_addr); end
    reset = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rel_req got=%b exp=1", imem_req); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] a;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      a = 32'h1000 + 32'(4 * k);
      n_checks++; if (imem_addr !== a) begin n_fail++; $display("FAIL zw_addr got=%h exp=%h", imem_addr, a); end
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      n_checks++; if (if_valid !== 1'b1 || if_pc !== a) begin n_fail++; $display("FAIL zw_out got=%b/%h exp=1/%h", if_valid, if_pc, a); end
      n_checks++; if (if_instr !== mem_word(a)) begin n_fail++; $display("FAIL zw_instr got=%h exp=%h", if_instr, mem_word(a)); end
    end
  endtask

  task automatic test_latency();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      n_checks++; if (if_valid !== 1'b0 || if_instr !== NOP) begin n_fail++; $display("FAIL lat_bubble got=%b/%h exp=0/%h", if_valid, if_instr, NOP); end
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h1000) begin n_fail++; $display("FAIL lat_addr got=%b/%h exp=1/1000", imem_req, imem_addr); end
    end
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h1000) begin n_fail++; $display("FAIL lat_out got=%b/%h exp=1/1000", if_valid, if_pc); end
  endtask

  // Continues from test_latency: 0x1004 is on the bus.
  task automatic test_stall_hold();
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (if_pc !== 32'h1000 || if_instr !== mem_word(32'h1000)) begin n_fail++; $display("FAIL hold_frozen got=%h/%h exp=1000/%h", if_pc, if_instr, mem_word(32'h1000)); end
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req got=%b exp=0", imem_req); end
      tick(1'b0, 1'b1, 1'b0, 32'h0);
    end
    n_checks++; if (imem_req !== 1'b0 || if_pc !== 32'h1000) begin n_fail++; $display("FAIL hold_last got=%b/%h exp=0/1000", imem_req, if_pc); end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (if_pc !== 32'h1004 || if_valid !== 1'b1 || if_instr !== mem_word(32'h1004)) begin n_fail++; $display("FAIL hold_rel got=%h/%b exp=1004/1", if_pc, if_valid); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h1008) begin n_fail++; $display("FAIL hold_next got=%b/%h exp=1/1008", imem_req, imem_addr); end
  endtask

  // Continues: 0x1008 outstanding.
  task automatic test_redirect_drain();
    tick(1'b0, 1'b0, 1'b1, 32'h2003);
    n_checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h1008) begin n_fail++; $display("FAIL drain_a got=%b/%b/%h exp=0/1/1008", if_valid, imem_req, imem_addr); end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (imem_addr !== 32'h1008) begin n_fail++; $display("FAIL drain_b got=%h exp=1008", imem_addr); end
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h2000) begin n_fail++; $display("FAIL drain_c got=%b/%h exp=0/2000", if_valid, imem_addr); end
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++; if (if_pc !== 32'h2000 || if_instr !== mem_word(32'h2000)) begin n_fail++; $display("FAIL drain_d got=%h/%h exp=2000/%h", if_pc, if_instr, mem_word(32'h2000)); end
  endtask

  task automatic test_redirect_stall_ready();
    tick(1'b1, 1'b1, 1'b1, 32'h3000);
    n_checks++; if (if_valid !== 1'b0 || if_instr !== NOP) begin n_fail++; $display("FAIL rsr_flush got=%b/%h exp=0/%h", if_valid, if_instr, NOP); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin n_fail++; $display("FAIL rsr_addr got=%b/%h exp=1/3000", imem_req, imem_addr); end
  endtask

  task automatic test_wrap_reset();
    tick(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
    n_checks++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_a got=%h exp=fffffffc", imem_addr); end
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++; if (if_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_b got=%h/%h exp=fffffffc/0", if_pc, imem_addr); end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    imem_ready = 1'b0;
    model_reset();
    #1;
    n_checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst got=%b/%b exp=0/0", imem_req, if_valid); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h1000) begin n_fail++; $display("FAIL mid_rst_rel got=%b/%h exp=1/1000", imem_req, imem_addr); end
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++; if (if_pc !== 32'h1000 || if_valid !== 1'b1) begin n_fail++; $display("FAIL mid_rst_out got=%h/%b exp=1000/1", if_pc, if_valid); end
  endtask

  task automatic test_random();
    logic        rdy, stl, rd;
    logic [31:0] rpc;
    do_reset();
    for (int k = 0; k < 800; k++) begin
      rdy = !m_parked && ($urandom_range(0, 99) < 60);
      stl = ($urandom_range(0, 99) < 30);
      rd  = ($urandom_range(0, 99) < 10);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      tick(rdy, stl, rd, rpc);
      n_checks++; if (imem_req !== !m_parked) begin n_fail++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", k, imem_req, !m_parked); end
      n_checks++; if (imem_addr !== m_addr) begin n_fail++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", k, imem_addr, m_addr); end
      n_checks++; if (if_valid !== e_v) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", k, if_valid, e_v); end
      n_checks++; if (if_instr !== e_i) begin n_fail++; $display("FAIL rnd_instr cyc=%0d got=%h exp=%h", k, if_instr, e_i); end
      n_checks++; if (if_pc !== e_pc) begin n_fail++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", k, if_pc, e_pc); end
    end
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b0; stall = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; imem_rdata = 32'h0;
    model_reset();
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall_hold();
    test_redirect_drain();
    test_redirect_stall_ready();
    test_wrap_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
